// File: rtl/lockin_phase_gen.sv
// -----------------------------------------------------------------------------
// lockin_phase_gen
//
// Dual-channel NCO phase stage for the lock-in reference path. Two phase
// accumulators advance on the sample-rate enable and produce truncated LUT
// addresses. New increment/offset words arriving from the CPU PIO must be
// stable for SETTLE clocks before they are armed. Once armed they are committed
// to both channels at the same edge, on a channel-1 wrap, so the reference
// never glitches mid-period.
//
// Ports:
//   clk_clk          system clock
//   reset_reset_n    asynchronous active-low reset
//   ce               sample-rate enable for the accumulators
//   sync_clr         synchronous clear of both accumulators (phase alignment)
//   phase_incr_1/2   per-channel phase increments from PIO
//   phase_offs_1/2   per-channel phase offsets from PIO
//   phase_1/2        registered LUT addresses
//   phase_1_q        channel-1 address plus a quarter turn
//   wrap_1/2         one-cycle accumulator overflow pulses
//   cfg_pending      new configuration is settling or armed
//   cfg_applied      one-cycle pulse on the commit edge
// -----------------------------------------------------------------------------
module lockin_phase_gen #(
    parameter int PHASE_W = 20,
    parameter int ADDR_W  = 12,
    parameter int SETTLE  = 16
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               ce,
    input  logic               sync_clr,
    input  logic [PHASE_W-1:0] phase_incr_1,
    input  logic [PHASE_W-1:0] phase_incr_2,
    input  logic [PHASE_W-1:0] phase_offs_1,
    input  logic [PHASE_W-1:0] phase_offs_2,
    output logic [ADDR_W-1:0]  phase_1,
    output logic [ADDR_W-1:0]  phase_2,
    output logic [ADDR_W-1:0]  phase_1_q,
    output logic               wrap_1,
    output logic               wrap_2,
    output logic               cfg_pending,
    output logic               cfg_applied
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CFG_W = 4 * PHASE_W;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(SETTLE - 1);
    localparam logic [ADDR_W-1:0] QUARTER  = {2'b01, {(ADDR_W-2){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ARMED  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cntNext;
    logic [CFG_W-1:0]   r_snap;
    logic [CFG_W-1:0]   r_act;
    logic [PHASE_W-1:0] r_acc1;
    logic [PHASE_W-1:0] r_acc2;
    logic               r_wrap1;
    logic               r_wrap2;
    logic [ADDR_W-1:0]  r_phase1;
    logic [ADDR_W-1:0]  r_phase2;
    logic [ADDR_W-1:0]  r_phaseQ;
    logic               r_applied;

    logic [CFG_W-1:0]   w_inBundle;
    logic               w_change;
    logic               w_loadSnap;
    logic               w_commit;
    logic [PHASE_W-1:0] w_actIncr1;
    logic [PHASE_W-1:0] w_actIncr2;
    logic [PHASE_W-1:0] w_actOffs1;
    logic [PHASE_W-1:0] w_actOffs2;
    logic [PHASE_W:0]   w_sum1;
    logic [PHASE_W:0]   w_sum2;
    logic               w_carry1Live;
    logic [PHASE_W-1:0] w_offsSum1;
    logic [PHASE_W-1:0] w_offsSum2;
    logic [ADDR_W-1:0]  w_addr1;
    logic [ADDR_W-1:0]  w_addr2;

    assign w_inBundle = {phase_incr_1, phase_incr_2, phase_offs_1, phase_offs_2};
    assign w_change   = (w_inBundle != r_snap);

    assign w_actIncr1 = r_act[4*PHASE_W-1 -: PHASE_W];
    assign w_actIncr2 = r_act[3*PHASE_W-1 -: PHASE_W];
    assign w_actOffs1 = r_act[2*PHASE_W-1 -: PHASE_W];
    assign w_actOffs2 = r_act[PHASE_W-1   -: PHASE_W];

    assign w_sum1 = {1'b0, r_acc1} + {1'b0, w_actIncr1};
    assign w_sum2 = {1'b0, r_acc2} + {1'b0, w_actIncr2};

    // The carry only counts as a real wrap when the accumulator actually
    // advances; a sync_clr suppresses it exactly as it suppresses wrap_1.
    assign w_carry1Live = ce & ~sync_clr & w_sum1[PHASE_W];

    assign w_offsSum1 = r_acc1 + w_actOffs1;
    assign w_offsSum2 = r_acc2 + w_actOffs2;
    assign w_addr1    = w_offsSum1[PHASE_W-1 -: ADDR_W];
    assign w_addr2    = w_offsSum2[PHASE_W-1 -: ADDR_W];

    // Settle-and-commit next-state logic. Any change restarts the settle
    // window; an armed config commits on a channel-1 wrap, or at once when the
    // active channel-1 increment is zero and no wrap would ever arrive.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_loadSnap  = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_change) begin
                    w_loadSnap  = 1'b1;
                    w_cntNext   = CNT_INIT;
                    w_stateNext = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_change) begin
                    w_loadSnap = 1'b1;
                    w_cntNext  = CNT_INIT;
                end else if (r_cnt == '0) begin
                    w_stateNext = S_ARMED;
                end else begin
                    w_cntNext = r_cnt - CNT_W'(1);
                end
            end
            S_ARMED: begin
                if (w_change) begin
                    w_loadSnap  = 1'b1;
                    w_cntNext   = CNT_INIT;
                    w_stateNext = S_SETTLE;
                end else if (w_carry1Live || (w_actIncr1 == '0)) begin
                    w_commit    = 1'b1;
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Snapshot follows the PIO bundle; the active set only moves on commit.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_snap <= '0;
            r_act  <= '0;
        end else begin
            if (w_loadSnap) begin
                r_snap <= w_inBundle;
            end
            if (w_commit) begin
                r_act <= r_snap;
            end
        end
    end

    // Accumulators always use the increment active before this edge, so a
    // new increment takes effect from the ce after the commit.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_acc1  <= '0;
            r_acc2  <= '0;
            r_wrap1 <= 1'b0;
            r_wrap2 <= 1'b0;
        end else if (sync_clr) begin
            r_acc1  <= '0;
            r_acc2  <= '0;
            r_wrap1 <= 1'b0;
            r_wrap2 <= 1'b0;
        end else if (ce) begin
            r_acc1  <= w_sum1[PHASE_W-1:0];
            r_acc2  <= w_sum2[PHASE_W-1:0];
            r_wrap1 <= w_sum1[PHASE_W];
            r_wrap2 <= w_sum2[PHASE_W];
        end else begin
            r_wrap1 <= 1'b0;
            r_wrap2 <= 1'b0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_phase1  <= '0;
            r_phase2  <= '0;
            r_phaseQ  <= '0;
            r_applied <= 1'b0;
        end else begin
            r_phase1  <= w_addr1;
            r_phase2  <= w_addr2;
            r_phaseQ  <= w_addr1 + QUARTER;
            r_applied <= w_commit;
        end
    end

    assign phase_1     = r_phase1;
    assign phase_2     = r_phase2;
    assign phase_1_q   = r_phaseQ;
    assign wrap_1      = r_wrap1;
    assign wrap_2      = r_wrap2;
    assign cfg_pending = (r_state != S_IDLE);
    assign cfg_applied = r_applied;

endmodule

// File: tb/tb_lockin_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_lockin_phase_gen
//
// Self-checking bench for lockin_phase_gen. A cycle-level reference model,
// written in terms of "cycles the input has been stable" rather than a settle
// counter, predicts every output after each clock. Directed sequences and a
// small table of offset configurations exercise the corner cases, followed by
// a randomized run.
// -----------------------------------------------------------------------------
module tb_lockin_phase_gen;

    localparam int PW  = 20;
    localparam int AW  = 12;
    localparam int SET = 16;

    logic          clk = 1'b0;
    logic          rstN;
    logic          ce;
    logic          clr;
    logic [PW-1:0] inc1, inc2, off1, off2;
    logic [AW-1:0] phase_1, phase_2, phase_1_q;
    logic          wrap_1, wrap_2, cfg_pending, cfg_applied;

    lockin_phase_gen #(.PHASE_W(PW), .ADDR_W(AW), .SETTLE(SET)) dut (
        .clk_clk      (clk),
        .reset_reset_n(rstN),
        .ce           (ce),
        .sync_clr     (clr),
        .phase_incr_1 (inc1),
        .phase_incr_2 (inc2),
        .phase_offs_1 (off1),
        .phase_offs_2 (off2),
        .phase_1      (phase_1),
        .phase_2      (phase_2),
        .phase_1_q    (phase_1_q),
        .wrap_1       (wrap_1),
        .wrap_2       (wrap_2),
        .cfg_pending  (cfg_pending),
        .cfg_applied  (cfg_applied)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model state: index 0/1 = incr_1/incr_2, 2/3 = offs_1/offs_2.
    int unsigned mSnap[4];
    int unsigned mAct[4];
    int unsigned mAcc[2];
    bit          mPending;
    int          mStable;
    int unsigned mPh1, mPh2, mPhQ;
    bit          mW1, mW2, mApp;

    typedef struct {
        logic [PW-1:0] incr;
        logic [PW-1:0] offs1;
        logic [PW-1:0] offs2;
        logic [AW-1:0] expDiff;
    } vec_t;

    vec_t vecs[4];

    task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
        nChecks++;
        if (actual == expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [PW-1:0] i1, input logic [PW-1:0] i2,
                                 input logic [PW-1:0] o1, input logic [PW-1:0] o2,
                                 input logic ceV, input logic clrV);
        inc1 = i1;
        inc2 = i2;
        off1 = o1;
        off2 = o2;
        ce   = ceV;
        clr  = clrV;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mSnap[i] = 0;
            mAct[i]  = 0;
        end
        mAcc[0]  = 0;
        mAcc[1]  = 0;
        mPending = 0;
        mStable  = 0;
        mPh1 = 0; mPh2 = 0; mPhQ = 0;
        mW1 = 0; mW2 = 0; mApp = 0;
    endtask

    // One clock of the behavioural model, using the inputs present at the edge.
    task automatic modelStep();
        int unsigned modP;
        int unsigned in[4];
        int unsigned s1, s2;
        bit          c1, c2, changed, wrapCommit;
        modP  = 32'd1 << PW;
        in[0] = inc1;
        in[1] = inc2;
        in[2] = off1;
        in[3] = off2;
        s1 = mAcc[0] + mAct[0];
        s2 = mAcc[1] + mAct[1];
        c1 = (s1 >= modP);
        c2 = (s2 >= modP);
        mPh1 = ((mAcc[0] + mAct[2]) % modP) >> (PW - AW);
        mPh2 = ((mAcc[1] + mAct[3]) % modP) >> (PW - AW);
        mPhQ = (mPh1 + (32'd1 << (AW - 2))) % (32'd1 << AW);
        wrapCommit = ce && !clr && c1;
        if (clr) begin
            mAcc[0] = 0; mAcc[1] = 0; mW1 = 0; mW2 = 0;
        end else if (ce) begin
            mAcc[0] = s1 % modP; mAcc[1] = s2 % modP; mW1 = c1; mW2 = c2;
        end else begin
            mW1 = 0; mW2 = 0;
        end
        changed = 0;
        for (int i = 0; i < 4; i++) begin
            if (in[i] != mSnap[i]) changed = 1;
        end
        mApp = 0;
        if (changed) begin
            for (int i = 0; i < 4; i++) mSnap[i] = in[i];
            mPending = 1;
            mStable  = 0;
        end else if (mPending) begin
            if (mStable >= SET && (wrapCommit || mAct[0] == 0)) begin
                for (int i = 0; i < 4; i++) mAct[i] = mSnap[i];
                mPending = 0;
                mApp     = 1;
            end else begin
                mStable++;
            end
        end
    endtask

    task automatic compareModel();
        checkOutput("phase_1", phase_1, mPh1);
        checkOutput("phase_2", phase_2, mPh2);
        checkOutput("phase_1_q", phase_1_q, mPhQ);
        checkOutput("wrap_1", wrap_1, mW1);
        checkOutput("wrap_2", wrap_2, mW2);
        checkOutput("cfg_pending", cfg_pending, mPending);
        checkOutput("cfg_applied", cfg_applied, mApp);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rstN) modelReset();
        else modelStep();
        #1;
        compareModel();
    endtask

    task automatic waitApplied(input int maxCycles, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!cfg_applied && n < maxCycles);
        checkOutput("commit_seen", cfg_applied, 1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int lastWrap;
        int appCount;
        logic [AW-1:0] prev;
        logic [AW-1:0] d;
        logic [AW-1:0] dq;

        vecs[0] = '{20'h10000, 20'h40000, 20'h00000, 12'h400};
        vecs[1] = '{20'h08000, 20'h80000, 20'h10000, 12'h700};
        vecs[2] = '{20'h02000, 20'h00000, 20'hC0000, 12'h400};
        vecs[3] = '{20'h10000, 20'hFFF00, 20'h00100, 12'hFFE};

        rstN = 1'b0;
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b0);
        modelReset();
        tick();
        tick();
        #3;
        rstN = 1'b1;
        tick();
        tick();

        // Reset then first update: commit via zero active increment.
        $display("[TB] first update");
        applyStimulus(20'h10000, '0, '0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("pending_rise", cfg_pending, 1);
        waitApplied(40, n);
        checkOutput("first_commit_latency", n, 17);
        tick();
        prev = phase_1;
        lastWrap = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            d = phase_1 - prev;
            checkOutput("phase1_step", d, 12'h100);
            prev = phase_1;
            if (wrap_1) begin
                if (lastWrap >= 0) checkOutput("wrap1_period", i - lastWrap, 16);
                lastWrap = i;
            end
        end

        // Offset table: align accumulators after each commit, then compare.
        $display("[TB] offset table");
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].incr, vecs[v].incr, vecs[v].offs1, vecs[v].offs2, 1'b1, 1'b0);
            waitApplied(300, n);
            clr = 1'b1;
            tick();
            clr = 1'b0;
            tick();
            for (int i = 0; i < 8; i++) begin
                tick();
                d  = phase_1 - phase_2;
                dq = phase_1_q - phase_1;
                checkOutput("offset_diff", d, vecs[v].expDiff);
                checkOutput("quad_diff", dq, 12'h400);
            end
        end

        // Wrap-aligned commit of a new channel-1 increment.
        $display("[TB] wrap-aligned commit");
        applyStimulus(20'h10000, 20'h10000, '0, '0, 1'b1, 1'b0);
        waitApplied(300, n);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        inc1 = 20'h20000;
        waitApplied(300, n);
        checkOutput("wrap_at_commit", wrap_1, 1);
        checkOutput("phase_at_commit", phase_1, 12'hF00);
        tick();
        checkOutput("phase_after_commit", phase_1, 12'h000);
        tick();
        checkOutput("phase_new_slope", phase_1, 12'h200);

        // sync_clr with ce while the accumulator is about to wrap.
        $display("[TB] sync_clr");
        applyStimulus(20'h10000, 20'h10000, 20'h40000, '0, 1'b1, 1'b0);
        waitApplied(300, n);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        clr = 1'b1;
        tick();
        checkOutput("clr_wrap1", wrap_1, 0);
        checkOutput("clr_no_commit", cfg_applied, 0);
        clr = 1'b0;
        tick();
        checkOutput("clr_phase1", phase_1, 12'h400);

        // Split write: the second change restarts the settle window.
        $display("[TB] split write");
        appCount = 0;
        inc1 = 20'h30000;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cfg_applied) appCount++;
        end
        off1 = 20'h20000;
        waitApplied(300, n);
        if (cfg_applied) appCount++;
        checkOutput("split_latency_ok", (n >= 17) ? 1 : 0, 1);
        clr = 1'b1;
        tick();
        if (cfg_applied) appCount++;
        clr = 1'b0;
        tick();
        if (cfg_applied) appCount++;
        checkOutput("split_offs", phase_1, 12'h200);
        tick();
        if (cfg_applied) appCount++;
        checkOutput("split_incr", phase_1, 12'h500);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cfg_applied) appCount++;
        end
        checkOutput("split_applied_count", appCount, 1);

        // Async reset in the middle of a settle window.
        $display("[TB] async reset mid-settle");
        applyStimulus(20'h50000, 20'h10000, 20'h12345, 20'h0ABCD, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) tick();
        #2;
        rstN = 1'b0;
        #1;
        modelReset();
        compareModel();
        tick();
        tick();
        #3;
        rstN = 1'b1;
        tick();
        checkOutput("pending_after_reset", cfg_pending, 1);
        waitApplied(40, n);
        checkOutput("reset_commit_latency", n, 17);

        // Randomized traffic against the model.
        $display("[TB] random run");
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(59) == 0) begin
                int w;
                logic [PW-1:0] val;
                w   = $urandom_range(3);
                val = ($urandom_range(7) == 0) ? '0 : PW'($urandom);
                case (w)
                    0: inc1 = val;
                    1: inc2 = val;
                    2: off1 = val;
                    default: off2 = val;
                endcase
            end
            ce  = ($urandom_range(3) != 0);
            clr = ($urandom_range(49) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
